alu_cmd_sequencer: RTL and testbench

Upstream controller that feeds the 4-bit combinational alu.
- Accepts commands over a valid/ready handshake and drives the ALU operands and select from registers.
- Captures the ALU result and flags into an accumulator.
- Returns the accumulator and flags on a valid/ready response channel.
- Turns the combinational ALU into a sequenced accumulator datapath for the surrounding design.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 51 +++++
 rtl/alu_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit alu and its command sequencer:
// opcodes, command modes and the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef enum logic [1:0] {
        MODE_LOAD      = 2'b00,
        MODE_EXEC_WB   = 2'b01,
        MODE_EXEC_TEST = 2'b10,
        MODE_CLEAR     = 2'b11
    } cmd_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit alu driven by the sequencer. Carry is carry-out for
// ADD, borrow for SUB, the shifted-out bit for shifts, and 0 for logic ops.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (sel)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            ALU_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences commands through an external combinational alu into an
// accumulator, returning acc and flags on a valid/ready response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_acc,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic [COUNT_W-1:0] op_count
);

    seq_state_t       state, state_nx;
    cmd_mode_t        mode_q;
    logic [WIDTH-1:0] acc;
    logic             carry_q, zero_q;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // cmd_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) state_nx = ST_EXEC;
            end
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    // alu_b/alu_sel double as the registered b and op for the command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_LOAD;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            acc      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            op_count <= '0;
        end else begin
            if (accept) begin
                mode_q  <= cmd_mode_t'(cmd_mode);
                alu_a   <= acc;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
            end
            if (state == ST_EXEC) begin
                case (mode_q)
                    MODE_LOAD: begin
                        acc     <= alu_b;
                        carry_q <= 1'b0;
                        zero_q  <= (alu_b == '0);
                    end
                    MODE_EXEC_WB: begin
                        acc     <= alu_result;
                        carry_q <= alu_carry;
                        zero_q  <= alu_zero;
                    end
                    MODE_EXEC_TEST: begin
                        carry_q <= alu_carry;
                        zero_q  <= alu_zero;
                    end
                    default: begin
                        acc     <= '0;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b1;
                    end
                endcase
                if ((mode_q == MODE_EXEC_WB || mode_q == MODE_EXEC_TEST) &&
                    op_count != '1)
                    op_count <= op_count + 1'b1;
            end
        end
    end

    assign rsp_acc   = acc;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer wired to the alu, with hand-computed
// expectations for each response.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_b = 4'h0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_acc;
    logic       rsp_carry, rsp_zero;
    logic [7:0] op_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(4), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_acc(rsp_acc), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .op_count(op_count)
    );

    alu #(.WIDTH(4)) u_alu (
        .a(alu_a), .b(alu_b), .sel(alu_sel),
        .result(alu_result), .carry(alu_carry), .zero(alu_zero)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers a command, checks the EXEC cycle, returns in RESP (accept+2).
    task automatic send(input logic [1:0] m, input logic [2:0] op, input logic [3:0] b,
                        input logic [3:0] exp_a, input string tag);
        int n = 0;
        cmd_valid = 1'b1; cmd_mode = m; cmd_op = op; cmd_b = b;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 8'(cmd_ready), 8'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, "_exec_rv"}, 8'(rsp_valid), 8'd0);
        chk({tag, "_exec_rdy"}, 8'(cmd_ready), 8'd0);
        chk({tag, "_alu_a"}, 8'(alu_a), 8'(exp_a));
        chk({tag, "_alu_b"}, 8'(alu_b), 8'(b));
        chk({tag, "_alu_sel"}, 8'(alu_sel), 8'(op));
        @(posedge clk); #1;
        chk({tag, "_rv"}, 8'(rsp_valid), 8'd1);
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] acc, input logic c,
                             input logic z, input logic [7:0] cnt);
        chk({tag, "_acc"}, 8'(rsp_acc), 8'(acc));
        chk({tag, "_carry"}, 8'(rsp_carry), 8'(c));
        chk({tag, "_zero"}, 8'(rsp_zero), 8'(z));
        chk({tag, "_cnt"}, op_count, cnt);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done_rv"}, 8'(rsp_valid), 8'd0);
    endtask

    initial begin
        // reset with a command held at the input: it must not be taken
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_b = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 8'(cmd_ready), 8'd0);
        chk("rst_rv", 8'(rsp_valid), 8'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rv", 8'(rsp_valid), 8'd0);
        chk("rel_ready", 8'(cmd_ready), 8'd1);
        check_rsp("rel", 4'h0, 1'b0, 1'b1, 8'd0);
        chk("rel_alu_a", 8'(alu_a), 8'd0);
        chk("rel_alu_sel", 8'(alu_sel), 8'd0);

        send(2'b00, ALU_ADD, 4'b0101, 4'h0, "load5");
        check_rsp("load5", 4'b0101, 1'b0, 1'b0, 8'd0);
        finish_rsp("load5");

        send(2'b01, ALU_ADD, 4'b0011, 4'b0101, "add3");
        check_rsp("add3", 4'b1000, 1'b0, 1'b0, 8'd1);
        finish_rsp("add3");

        send(2'b00, ALU_ADD, 4'b1100, 4'b1000, "loadc");
        check_rsp("loadc", 4'b1100, 1'b0, 1'b0, 8'd1);
        finish_rsp("loadc");
        send(2'b01, ALU_ADD, 4'b0100, 4'b1100, "addovf");
        check_rsp("addovf", 4'b0000, 1'b1, 1'b1, 8'd2);
        finish_rsp("addovf");

        // backpressure with a CLEAR waiting at the input
        send(2'b00, ALU_ADD, 4'b0101, 4'b0000, "bp");
        cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_op = ALU_ADD; cmd_b = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_rv", 8'(rsp_valid), 8'd1);
            chk("bp_hold_acc", 8'(rsp_acc), 8'd5);
            chk("bp_hold_ready", 8'(cmd_ready), 8'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle_rv", 8'(rsp_valid), 8'd0);
        chk("bp_idle_ready", 8'(cmd_ready), 8'd1);
        chk("bp_idle_acc", 8'(rsp_acc), 8'd5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("clr_exec_ready", 8'(cmd_ready), 8'd0);
        @(posedge clk); #1;
        chk("clr_rv", 8'(rsp_valid), 8'd1);
        check_rsp("clr", 4'h0, 1'b0, 1'b1, 8'd2);
        finish_rsp("clr");

        send(2'b00, ALU_ADD, 4'b0101, 4'h0, "tload");
        finish_rsp("tload");
        send(2'b10, ALU_SUB, 4'b0101, 4'b0101, "test");
        check_rsp("test", 4'b0101, 1'b0, 1'b1, 8'd3);
        finish_rsp("test");

        send(2'b00, ALU_ADD, 4'b0011, 4'b0101, "sload");
        finish_rsp("sload");
        send(2'b01, ALU_SUB, 4'b0101, 4'b0011, "subb");
        check_rsp("subb", 4'b1110, 1'b1, 1'b0, 8'd4);
        finish_rsp("subb");

        // reset during EXEC
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_op = ALU_ADD; cmd_b = 4'b1010;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid_in_exec", 8'(cmd_ready), 8'd0);
        rst_n = 1'b0;
        #1;
        check_rsp("mid_rst", 4'h0, 1'b0, 1'b1, 8'd0);
        chk("mid_rst_alu_b", 8'(alu_b), 8'd0);
        chk("mid_rst_rv", 8'(rsp_valid), 8'd0);
        chk("mid_rst_ready", 8'(cmd_ready), 8'd0);
        @(posedge clk); #1;
        chk("mid_rst_rv2", 8'(rsp_valid), 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("mid_post_rv", 8'(rsp_valid), 8'd0);
            chk("mid_post_ready", 8'(cmd_ready), 8'd1);
        end

        // saturation: 260 ADD 1 commands from acc=0, op_count=0
        for (int i = 0; i < 260; i++) begin
            send(2'b01, ALU_ADD, 4'b0001, 4'(i), "sat");
            if (i == 253) chk("sat_254", op_count, 8'd254);
            if (i == 254) chk("sat_255", op_count, 8'd255);
            finish_rsp("sat");
        end
        check_rsp("sat_end", 4'h4, 1'b0, 1'b0, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
